// File: rtl/debounce_pkg.sv
// Purpose: shared types and helpers for the multi-channel contact debouncer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
//
// Contents:
//   chan_state_t - per-channel qualification state
//   max_of()     - constant helper used to size the shared rise/fall counter
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_RISE   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_FALL   = 2'd3
  } chan_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_multi_if.sv
// Purpose: bundle of raw contact inputs and debounced outputs for debounce_multi.
// Latency: n/a (wiring only).
// Backpressure: none; outputs are levels and single-cycle event pulses.
//
// Signals (all NUM_CHANNELS wide, one bit per channel):
//   IN_SIGNAL           raw asynchronous contact inputs (driven by master)
//   OUT_DEBOUNCE_SIGNAL debounced levels
//   OUT_RISE_PULSE      one-cycle pulse on a 0->1 output change
//   OUT_FALL_PULSE      one-cycle pulse on a 1->0 output change
// Modports: master = input source / event consumer, slave = the debouncer.
interface debounce_multi_if #(
  parameter int NUM_CHANNELS = 4
);

  logic [NUM_CHANNELS-1:0] IN_SIGNAL;
  logic [NUM_CHANNELS-1:0] OUT_DEBOUNCE_SIGNAL;
  logic [NUM_CHANNELS-1:0] OUT_RISE_PULSE;
  logic [NUM_CHANNELS-1:0] OUT_FALL_PULSE;

  modport master (
    output IN_SIGNAL,
    input  OUT_DEBOUNCE_SIGNAL,
    input  OUT_RISE_PULSE,
    input  OUT_FALL_PULSE
  );

  modport slave (
    input  IN_SIGNAL,
    output OUT_DEBOUNCE_SIGNAL,
    output OUT_RISE_PULSE,
    output OUT_FALL_PULSE
  );

endinterface

// File: rtl/debounce_channel.sv
// Purpose: one debounced channel - optional 2-flop synchroniser, rise/fall
//          qualification FSM with a shared saturating counter, registered pulses.
// Latency: RISE (or FALL) edges from the first edge sampling the new level,
//          plus 2 when DEBOUNCE_SYNC_EN is defined. Backpressure: none.
//
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   raw         contact input (asynchronous if DEBOUNCE_SYNC_EN is defined)
//   level       debounced level
//   rise_pulse  high for the first cycle of a new high level
//   fall_pulse  high for the first cycle of a new low level
// Build macro: DEBOUNCE_SYNC_EN (adds the synchroniser; otherwise raw must
//              already be synchronous to clk).
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int RISE        = 8,
  parameter int FALL        = 6,
  parameter int RESET_LEVEL = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CNT_MAX = max_of(RISE, FALL);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic              RST_BIT   = (RESET_LEVEL != 0);
  localparam chan_state_t       RST_STATE = RST_BIT ? STABLE_HIGH : STABLE_LOW;
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE - 1);
  localparam logic [CNT_W-1:0]  FALL_LAST = CNT_W'(FALL - 1);
  localparam logic [CNT_W-1:0]  CNT_TOP   = CNT_W'(CNT_MAX);

  logic s;

`ifdef DEBOUNCE_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{RST_BIT}};
    end else begin
      sync_q <= {sync_q[0], raw};
    end
  end

  assign s = sync_q[1];
`else
  assign s = raw;
`endif

  chan_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      level_q <= RST_BIT;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // The first sample of the new level counts as 1, so the transition fires when
  // the counter already holds RISE-1 (FALL-1) and one more matching sample arrives.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;

    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          if (RISE == 1) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            state_d = WAIT_RISE;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      WAIT_RISE: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == RISE_LAST) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      STABLE_HIGH: begin
        if (!s) begin
          if (FALL == 1) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            state_d = WAIT_FALL;
            cnt_d   = CNT_W'(1);
          end
        end
      end

      WAIT_FALL: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == FALL_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
        level_d = RST_BIT;
      end
    endcase
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/debounce_multi.sv
// Purpose: NUM_CHANNELS independent contact debouncers with level and edge pulses.
// Latency: RISE/FALL edges after the first edge sampling the new level, +2 with
//          DEBOUNCE_SYNC_EN defined. Backpressure: none; pulses are fire-and-forget.
//
// Ports:
//   IN_CLOCK  single clock, rising edge
//   IN_RESET  asynchronous active-high reset
//   bus       debounce_multi_if.slave: IN_SIGNAL in, OUT_DEBOUNCE_SIGNAL,
//             OUT_RISE_PULSE, OUT_FALL_PULSE out (NUM_CHANNELS bits each)
// Build macro: DEBOUNCE_SYNC_EN enables the per-channel 2-flop synchroniser.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int NUM_CHANNELS                 = 4,
  parameter int DEAD_TIME_NUM_CLKS_RISE_EDGE = 8,
  parameter int DEAD_TIME_NUM_CLKS_FALL_EDGE = 6,
  parameter int RESET_LEVEL                  = 0
) (
  input  logic             IN_CLOCK,
  input  logic             IN_RESET,
  debounce_multi_if.slave  bus
);

  logic [NUM_CHANNELS-1:0] level;
  logic [NUM_CHANNELS-1:0] rise;
  logic [NUM_CHANNELS-1:0] fall;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    debounce_channel #(
      .RISE        (DEAD_TIME_NUM_CLKS_RISE_EDGE),
      .FALL        (DEAD_TIME_NUM_CLKS_FALL_EDGE),
      .RESET_LEVEL (RESET_LEVEL)
    ) u_chan (
      .clk        (IN_CLOCK),
      .rst        (IN_RESET),
      .raw        (bus.IN_SIGNAL[g]),
      .level      (level[g]),
      .rise_pulse (rise[g]),
      .fall_pulse (fall[g])
    );
  end

  assign bus.OUT_DEBOUNCE_SIGNAL = level;
  assign bus.OUT_RISE_PULSE      = rise;
  assign bus.OUT_FALL_PULSE      = fall;

endmodule

// File: tb/tb_debounce_multi.sv
// Purpose: directed self-checking bench for debounce_multi (three configurations).
// Latency: expectations follow RISE/FALL plus synchroniser depth of this build.
// Backpressure: n/a.
module tb_debounce_multi;

`ifdef DEBOUNCE_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  localparam int RA = 8;  // rise qualification, DUTs a and c
  localparam int FA = 6;  // fall qualification, DUTs a and c
  localparam int RB = 6;  // rise = fall for DUT b

  logic clk;
  logic rst;

  debounce_multi_if #(.NUM_CHANNELS(4)) if_a ();
  debounce_multi_if #(.NUM_CHANNELS(4)) if_b ();
  debounce_multi_if #(.NUM_CHANNELS(1)) if_c ();

  debounce_multi #(
    .NUM_CHANNELS(4), .DEAD_TIME_NUM_CLKS_RISE_EDGE(RA),
    .DEAD_TIME_NUM_CLKS_FALL_EDGE(FA), .RESET_LEVEL(0)
  ) u_dut_a (.IN_CLOCK(clk), .IN_RESET(rst), .bus(if_a));

  debounce_multi #(
    .NUM_CHANNELS(4), .DEAD_TIME_NUM_CLKS_RISE_EDGE(RB),
    .DEAD_TIME_NUM_CLKS_FALL_EDGE(RB), .RESET_LEVEL(0)
  ) u_dut_b (.IN_CLOCK(clk), .IN_RESET(rst), .bus(if_b));

  debounce_multi #(
    .NUM_CHANNELS(1), .DEAD_TIME_NUM_CLKS_RISE_EDGE(RA),
    .DEAD_TIME_NUM_CLKS_FALL_EDGE(FA), .RESET_LEVEL(1)
  ) u_dut_c (.IN_CLOCK(clk), .IN_RESET(rst), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Running pulse totals, sampled on the falling edge.
  int rise_tot_a = 0, fall_tot_a = 0;
  int rise_tot_c = 0, fall_tot_c = 0;

  always @(negedge clk) begin
    rise_tot_a += $countones(if_a.OUT_RISE_PULSE);
    fall_tot_a += $countones(if_a.OUT_FALL_PULSE);
    rise_tot_c += $countones(if_c.OUT_RISE_PULSE);
    fall_tot_c += $countones(if_c.OUT_FALL_PULSE);
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance n falling edges, then settle 1 time unit past them.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  int r0, f0;

  initial begin
    rst = 1'b1;
    if_a.IN_SIGNAL = 4'b0000;
    if_b.IN_SIGNAL = 4'b0000;
    if_c.IN_SIGNAL = 1'b1;

    // Reset state, before any clock edge.
    #2;
    check_val("rst_out_a",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("rst_rise_a", 32'(if_a.OUT_RISE_PULSE), 32'h0);
    check_val("rst_fall_a", 32'(if_a.OUT_FALL_PULSE), 32'h0);
    check_val("rst_out_b",  32'(if_b.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("rst_out_c",  32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("rst_fall_c", 32'(if_c.OUT_FALL_PULSE), 32'h0);

    tick(2);
    rst = 1'b0;

    // Quiet period after release: no pulses.
    tick(20);
    check_val("quiet_out_a",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("quiet_rise_a", 32'(rise_tot_a), 32'd0);
    check_val("quiet_fall_a", 32'(fall_tot_a), 32'd0);
    check_val("quiet_out_c",  32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("quiet_pls_c",  32'(rise_tot_c + fall_tot_c), 32'd0);

    // Clean rise on channel 0.
    r0 = rise_tot_a;
    if_a.IN_SIGNAL[0] = 1'b1;
    tick(RA + SYNC_LAT - 1);
    check_val("clean_pre_out",   32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    tick(1);
    check_val("clean_out",       32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("clean_rise_pls",  32'(if_a.OUT_RISE_PULSE), 32'h1);
    tick(1);
    check_val("clean_rise_done", 32'(if_a.OUT_RISE_PULSE), 32'h0);
    check_val("clean_out_hold",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("clean_rise_cnt",  32'(rise_tot_a - r0), 32'd1);

    // Return channel 0 low, then bounce: 5 high, 1 low, then steady high.
    if_a.IN_SIGNAL[0] = 1'b0;
    tick(FA + SYNC_LAT + 2);
    check_val("bounce_start_out", 32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    r0 = rise_tot_a;
    if_a.IN_SIGNAL[0] = 1'b1;
    tick(5);
    if_a.IN_SIGNAL[0] = 1'b0;
    tick(1);
    if_a.IN_SIGNAL[0] = 1'b1;
    tick(RA + SYNC_LAT - 1);
    check_val("bounce_pre_out",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("bounce_no_pls",   32'(rise_tot_a - r0), 32'd0);
    tick(1);
    check_val("bounce_out",      32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("bounce_rise_pls", 32'(if_a.OUT_RISE_PULSE), 32'h1);
    tick(1);
    check_val("bounce_rise_cnt", 32'(rise_tot_a - r0), 32'd1);

    // Channel 1 high, 1-cycle low glitch, then steady low.
    if_a.IN_SIGNAL[1] = 1'b1;
    tick(RA + SYNC_LAT + 1);
    check_val("glitch_hi_out", 32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h3);
    f0 = fall_tot_a;
    if_a.IN_SIGNAL[1] = 1'b0;
    tick(1);
    if_a.IN_SIGNAL[1] = 1'b1;
    tick(10);
    check_val("glitch_out",    32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h3);
    check_val("glitch_no_pls", 32'(fall_tot_a - f0), 32'd0);
    if_a.IN_SIGNAL[1] = 1'b0;
    tick(FA + SYNC_LAT - 1);
    check_val("fall_pre_out",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h3);
    tick(1);
    check_val("fall_out",      32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("fall_pls",      32'(if_a.OUT_FALL_PULSE), 32'h2);
    check_val("fall_no_rise",  32'(if_a.OUT_RISE_PULSE), 32'h0);
    tick(1);
    check_val("fall_cnt",      32'(fall_tot_a - f0), 32'd1);

    // Reset mid-qualification on channel 2 (counter at 5), asynchronous assert.
    if_a.IN_SIGNAL[2] = 1'b1;
    tick(SYNC_LAT + 5);
    check_val("midq_pre_out", 32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_val("midq_async_out",  32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("midq_async_rise", 32'(if_a.OUT_RISE_PULSE), 32'h0);
    check_val("midq_async_fall", 32'(if_a.OUT_FALL_PULSE), 32'h0);
    r0 = rise_tot_a;
    f0 = fall_tot_a;
    tick(2);
    rst = 1'b0;
    tick(RA + SYNC_LAT - 1);
    check_val("midq_pre_rise", 32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("midq_no_pls",   32'(rise_tot_a - r0 + fall_tot_a - f0), 32'd0);
    tick(1);
    check_val("midq_out",      32'(if_a.OUT_DEBOUNCE_SIGNAL), 32'h5);
    check_val("midq_rise_pls", 32'(if_a.OUT_RISE_PULSE), 32'h5);

    // Simultaneous rise on ch2 and fall on ch3 (RISE = FALL).
    if_b.IN_SIGNAL[3] = 1'b1;
    tick(RB + SYNC_LAT + 1);
    check_val("sim_setup_out", 32'(if_b.OUT_DEBOUNCE_SIGNAL), 32'h8);
    if_b.IN_SIGNAL = 4'b0100;
    tick(RB + SYNC_LAT - 1);
    check_val("sim_pre_out",   32'(if_b.OUT_DEBOUNCE_SIGNAL), 32'h8);
    tick(1);
    check_val("sim_out",       32'(if_b.OUT_DEBOUNCE_SIGNAL), 32'h4);
    check_val("sim_rise_pls",  32'(if_b.OUT_RISE_PULSE), 32'h4);
    check_val("sim_fall_pls",  32'(if_b.OUT_FALL_PULSE), 32'h8);
    tick(1);
    check_val("sim_pls_clear", 32'({if_b.OUT_RISE_PULSE, if_b.OUT_FALL_PULSE}), 32'h0);

    // RESET_LEVEL=1: reset during fall qualification (counter at 5).
    if_c.IN_SIGNAL = 1'b0;
    tick(SYNC_LAT + 5);
    check_val("rl1_pre_out", 32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_val("rl1_async_out",  32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("rl1_async_fall", 32'(if_c.OUT_FALL_PULSE), 32'h0);
    f0 = fall_tot_c;
    tick(2);
    rst = 1'b0;
    tick(FA + SYNC_LAT - 1);
    check_val("rl1_pre_fall", 32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("rl1_no_pls",   32'(fall_tot_c - f0), 32'd0);
    tick(1);
    check_val("rl1_fall_out", 32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h0);
    check_val("rl1_fall_pls", 32'(if_c.OUT_FALL_PULSE), 32'h1);
    if_c.IN_SIGNAL = 1'b1;
    tick(RA + SYNC_LAT - 1);
    check_val("rl1_pre_rise", 32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h0);
    tick(1);
    check_val("rl1_rise_out", 32'(if_c.OUT_DEBOUNCE_SIGNAL), 32'h1);
    check_val("rl1_rise_pls", 32'(if_c.OUT_RISE_PULSE), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
